rom_loader: RTL and testbench

Boot-time image writer on the 6502 memory bus. It holds the CPU in reset, accepts a byte stream and writes it into program memory starting at `BASE_ADDR`, then writes the reset vector at 0xFFFC/0xFFFD and releases the CPU. The CPU only ever reads program memory; this block is the write side of that memory port. It replaces preloading memory from testbench backdoors.

---
 rtl/rom_loader_pkg.sv | 20 ++
 rtl/rom_loader_cksum.sv | 19 +
 rtl/rom_loader.sv | 155 +++++++++++++++
 tb/tb_rom_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot-time image writer rom_loader.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_VECLO,
    S_VECHI,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [15:0] VEC_LO_ADDR       = 16'hFFFC;
  localparam logic [15:0] VEC_HI_ADDR       = 16'hFFFD;
  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hF000;
  localparam int          DEFAULT_LEN       = 4096;

endpackage

// File: rtl/rom_loader_cksum.sv
// 8-bit running sum of image bytes for rom_loader's trailer check.
module rom_loader_cksum (
  input  logic       ph1,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge ph1) begin
    if (reset || clear) begin
      sum <= 8'h00;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Writes a streamed image into 6502 program memory, then the reset vector, then releases the CPU.
// Optional trailer checksum is enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          LEN         = DEFAULT_LEN,
  parameter logic [15:0] RESET_VEC   = 16'hF000,
  parameter int          HOLD_CYCLES = 8
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  localparam int HW = $clog2(HOLD_CYCLES + 2);

  state_t        state;
  logic [16:0]   count;
  logic [HW-1:0] hold_cnt;
  logic          last_byte;
  logic [15:0]   wr_addr;

  assign last_byte = in_last || (count == 17'(LEN - 1));
  assign wr_addr   = BASE_ADDR + count[15:0];

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       ck_clear;
  logic       ck_en;
  logic       ck_ok;

  assign ck_clear = start && (state == S_IDLE || state == S_ERROR);
  assign ck_en    = (state == S_LOAD) && in_valid;
  assign ck_ok    = (8'(sum + in_data) == 8'h00);

  rom_loader_cksum u_cksum (
    .ph1   (ph1),
    .reset (reset),
    .clear (ck_clear),
    .en    (ck_en),
    .din   (in_data),
    .sum   (sum)
  );
`else
  assign err = 1'b0;
`endif

  // hold_cnt starts at HOLD_CYCLES+1 on the VECHI edge so reset drops HOLD_CYCLES+1 cycles after the high vector byte commits
  always_ff @(posedge ph1) begin
    if (reset) begin
      state     <= S_IDLE;
      cpu_reset <= 1'b1;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      done      <= 1'b0;
      count     <= 17'd0;
      hold_cnt  <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      err       <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count    <= 17'd0;
            in_ready <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            mem_addr  <= wr_addr;
            mem_wdata <= in_data;
            mem_we    <= 1'b1;
            count     <= count + 17'd1;
            if (last_byte) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              state    <= S_CHECK;
`else
              in_ready <= 1'b0;
              state    <= S_VECLO;
`endif
            end
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (ck_ok) begin
              state <= S_VECLO;
            end else begin
              err   <= 1'b1;
              state <= S_ERROR;
            end
          end
        end
        S_ERROR: begin
          if (start) begin
            err      <= 1'b0;
            count    <= 17'd0;
            in_ready <= 1'b1;
            state    <= S_LOAD;
          end
        end
`endif
        S_VECLO: begin
          mem_addr  <= VEC_LO_ADDR;
          mem_wdata <= RESET_VEC[7:0];
          mem_we    <= 1'b1;
          state     <= S_VECHI;
        end
        S_VECHI: begin
          mem_addr  <= VEC_HI_ADDR;
          mem_wdata <= RESET_VEC[15:8];
          mem_we    <= 1'b1;
          hold_cnt  <= HW'(HOLD_CYCLES + 1);
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt == '0) begin
            cpu_reset <= 1'b0;
            done      <= 1'b1;
            state     <= S_RUN;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        S_RUN: begin
          if (start) begin
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: default, LEN-limited and wrapping-base instances.
module tb_rom_loader;

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int HOLD = 8;

  logic       ph1 = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;

  logic        in_ready_a, mem_we_a, cpu_reset_a, done_a, err_a;
  logic [15:0] mem_addr_a;
  logic [7:0]  mem_wdata_a;
  logic        in_ready_b, mem_we_b, cpu_reset_b, done_b, err_b;
  logic [15:0] mem_addr_b;
  logic [7:0]  mem_wdata_b;
  logic        in_ready_c, mem_we_c, cpu_reset_c, done_c, err_c;
  logic [15:0] mem_addr_c;
  logic [7:0]  mem_wdata_c;

  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];
  logic [7:0]  mem_c [0:65535];
  logic [15:0] wq_a[$];
  logic [15:0] wq_b[$];
  logic [15:0] wq_c[$];

  int checks = 0;
  int failures = 0;

  always #5 ph1 = ~ph1;

  rom_loader #(.HOLD_CYCLES(HOLD)) dut_a (
    .ph1(ph1), .reset(reset), .start(start_a), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_we(mem_we_a), .cpu_reset(cpu_reset_a), .done(done_a), .err(err_a)
  );

  rom_loader #(.LEN(4), .HOLD_CYCLES(HOLD)) dut_b (
    .ph1(ph1), .reset(reset), .start(start_b), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_we(mem_we_b), .cpu_reset(cpu_reset_b), .done(done_b), .err(err_b)
  );

  rom_loader #(.BASE_ADDR(16'hFFFE), .HOLD_CYCLES(HOLD)) dut_c (
    .ph1(ph1), .reset(reset), .start(start_c), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_c), .mem_addr(mem_addr_c), .mem_wdata(mem_wdata_c),
    .mem_we(mem_we_c), .cpu_reset(cpu_reset_c), .done(done_c), .err(err_c)
  );

  // Behavioural program memories: commit on the ph1 edge where mem_we is high
  always @(posedge ph1) begin
    if (mem_we_a) begin mem_a[mem_addr_a] = mem_wdata_a; wq_a.push_back(mem_addr_a); end
    if (mem_we_b) begin mem_b[mem_addr_b] = mem_wdata_b; wq_b.push_back(mem_addr_b); end
    if (mem_we_c) begin mem_c[mem_addr_c] = mem_wdata_c; wq_c.push_back(mem_addr_c); end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge ph1);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    stepCycle();
  endtask

  task automatic pulseStart(input int sel);
    in_valid = 1'b0;
    in_last  = 1'b0;
    case (sel)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    stepCycle();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  function automatic logic doneOf(input int sel);
    case (sel)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic waitDone(input int sel, inout int cyc);
    int guard = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (!doneOf(sel) && guard < 300) begin
      stepCycle();
      cyc++;
      guard++;
    end
  endtask

  initial begin
    logic [7:0]  img [0:4];
    logic [15:0] exp_c [0:5];
    logic        tv [0:4];
    int cyc;
    int fall;

    img = '{8'hA9, 8'h55, 8'h8D, 8'h2A, 8'h02};
    exp_c = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFC, 16'hFFFD};
    tv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    $display("[TB] reset state");
    repeat (2) stepCycle();
    checkOutput("rst_cpu_reset", 32'(cpu_reset_a), 32'd1);
    checkOutput("rst_in_ready", 32'(in_ready_a), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we_a), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr_a), 32'h0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata_a), 32'h0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_err", 32'(err_a), 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("idle_in_ready", 32'(in_ready_a), 32'd0);

    $display("[TB] basic load");
    pulseStart(0);
    checkOutput("load_in_ready", 32'(in_ready_a), 32'd1);
    wq_a.delete();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, img[i], (i == 4));
      checkOutput($sformatf("basic_we_%0d", i), 32'(mem_we_a), 32'd1);
      checkOutput($sformatf("basic_addr_%0d", i), 32'(mem_addr_a), 32'hF000 + 32'(i));
    end
    cyc = 4;
    if (CK == 1) begin
      applyStimulus(1'b1, 8'h49, 1'b0);
      cyc++;
    end
    in_valid = 1'b0;
    fall = -1;
    while (!done_a && cyc < 300) begin
      stepCycle();
      cyc++;
      if (!cpu_reset_a && fall < 0) fall = cyc;
    end
    checkOutput("basic_done_cycle", 32'(cyc), 32'(5 + CK + 2 + HOLD + 1));
    checkOutput("basic_reset_fall", 32'(fall), 32'(5 + CK + 2 + HOLD + 1));
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("basic_mem_%0d", i), 32'(mem_a[16'hF000 + 16'(i)]), 32'(img[i]));
    checkOutput("basic_vec_lo", 32'(mem_a[16'hFFFC]), 32'h00);
    checkOutput("basic_vec_hi", 32'(mem_a[16'hFFFD]), 32'hF0);
    checkOutput("basic_writes", 32'(wq_a.size()), 32'd7);
    checkOutput("run_in_ready", 32'(in_ready_a), 32'd0);
    checkOutput("run_cpu_reset", 32'(cpu_reset_a), 32'd0);
    pulseStart(0);
    checkOutput("restart_cpu_reset", 32'(cpu_reset_a), 32'd1);
    checkOutput("restart_done", 32'(done_a), 32'd0);

    $display("[TB] throttled input");
    pulseStart(0);
    wq_a.delete();
    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("thr_we_0", 32'(mem_we_a), 32'(tv[0]));
    applyStimulus(1'b0, 8'h99, 1'b0);
    checkOutput("thr_we_1", 32'(mem_we_a), 32'(tv[1]));
    applyStimulus(1'b0, 8'h99, 1'b0);
    checkOutput("thr_we_2", 32'(mem_we_a), 32'(tv[2]));
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("thr_we_3", 32'(mem_we_a), 32'(tv[3]));
    applyStimulus(1'b1, 8'h33, 1'b1);
    checkOutput("thr_we_4", 32'(mem_we_a), 32'(tv[4]));
    if (CK == 1) applyStimulus(1'b1, 8'h9A, 1'b0);
    cyc = 0;
    waitDone(0, cyc);
    checkOutput("thr_done", 32'(done_a), 32'd1);
    checkOutput("thr_writes", 32'(wq_a.size()), 32'd5);
    checkOutput("thr_q0", 32'(wq_a[0]), 32'hF000);
    checkOutput("thr_q1", 32'(wq_a[1]), 32'hF001);
    checkOutput("thr_q2", 32'(wq_a[2]), 32'hF002);
    checkOutput("thr_q3", 32'(wq_a[3]), 32'hFFFC);
    checkOutput("thr_mem2", 32'(mem_a[16'hF002]), 32'h33);

    $display("[TB] reset mid-load");
    pulseStart(0);
    pulseStart(0);
    wq_a.delete();
    applyStimulus(1'b1, 8'h77, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    stepCycle();
    checkOutput("midrst_cpu_reset", 32'(cpu_reset_a), 32'd1);
    checkOutput("midrst_done", 32'(done_a), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready_a), 32'd0);
    checkOutput("midrst_mem_we", 32'(mem_we_a), 32'd0);
    reset = 1'b0;
    repeat (15) stepCycle();
    checkOutput("midrst_writes", 32'(wq_a.size()), 32'd2);
    checkOutput("midrst_mem0", 32'(mem_a[16'hF000]), 32'h77);
    checkOutput("midrst_mem1", 32'(mem_a[16'hF001]), 32'h66);
    checkOutput("midrst_idle_done", 32'(done_a), 32'd0);
    pulseStart(0);
    applyStimulus(1'b1, 8'h42, 1'b1);
    cyc = 0;
    if (CK == 1) begin
      applyStimulus(1'b1, 8'hBE, 1'b0);
      cyc++;
    end
    waitDone(0, cyc);
    checkOutput("reload_done_cycle", 32'(cyc), 32'(1 + CK + 2 + HOLD + 1));
    checkOutput("reload_mem0", 32'(mem_a[16'hF000]), 32'h42);

`ifndef ROM_LOADER_CHECKSUM_EN
    $display("[TB] LEN limit");
    pulseStart(1);
    wq_b.delete();
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("len_ready_%0d", k), 32'(in_ready_b), (k < 4) ? 32'd1 : 32'd0);
      applyStimulus(1'b1, 8'hB0 + 8'(k), 1'b0);
    end
    cyc = 5;
    waitDone(1, cyc);
    checkOutput("len_done_cycle", 32'(cyc), 32'(4 + 2 + HOLD + 1));
    checkOutput("len_writes", 32'(wq_b.size()), 32'd6);
    checkOutput("len_q3", 32'(wq_b[3]), 32'hF003);
    checkOutput("len_q4", 32'(wq_b[4]), 32'hFFFC);
    checkOutput("len_mem3", 32'(mem_b[16'hF003]), 32'hB3);
`endif

    $display("[TB] address wrap and vector override");
    pulseStart(2);
    wq_c.delete();
    applyStimulus(1'b1, 8'hE1, 1'b0);
    applyStimulus(1'b1, 8'hE2, 1'b0);
    applyStimulus(1'b1, 8'hE3, 1'b0);
    applyStimulus(1'b1, 8'hE4, 1'b1);
    if (CK == 1) applyStimulus(1'b1, 8'h76, 1'b0);
    cyc = 0;
    waitDone(2, cyc);
    checkOutput("wrap_done", 32'(done_c), 32'd1);
    checkOutput("wrap_writes", 32'(wq_c.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("wrap_q%0d", i), 32'(wq_c[i]), 32'(exp_c[i]));
    checkOutput("wrap_mem0000", 32'(mem_c[16'h0000]), 32'hE3);
    checkOutput("wrap_vec_lo", 32'(mem_c[16'hFFFC]), 32'h00);
    checkOutput("wrap_vec_hi", 32'(mem_c[16'hFFFD]), 32'hF0);

`ifdef ROM_LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad trailer");
    pulseStart(0);
    pulseStart(0);
    wq_a.delete();
    applyStimulus(1'b1, 8'h10, 1'b0);
    applyStimulus(1'b1, 8'h20, 1'b1);
    applyStimulus(1'b1, 8'hD0, 1'b0);
    cyc = 0;
    waitDone(0, cyc);
    checkOutput("ck_good_done", 32'(done_a), 32'd1);
    checkOutput("ck_good_err", 32'(err_a), 32'd0);
    checkOutput("ck_good_writes", 32'(wq_a.size()), 32'd4);
    pulseStart(0);
    pulseStart(0);
    wq_a.delete();
    applyStimulus(1'b1, 8'h10, 1'b0);
    applyStimulus(1'b1, 8'h20, 1'b1);
    applyStimulus(1'b1, 8'hD1, 1'b0);
    in_valid = 1'b0;
    repeat (15) stepCycle();
    checkOutput("ck_bad_err", 32'(err_a), 32'd1);
    checkOutput("ck_bad_cpu_reset", 32'(cpu_reset_a), 32'd1);
    checkOutput("ck_bad_done", 32'(done_a), 32'd0);
    checkOutput("ck_bad_writes", 32'(wq_a.size()), 32'd2);
    pulseStart(0);
    checkOutput("ck_restart_err", 32'(err_a), 32'd0);
    checkOutput("ck_restart_ready", 32'(in_ready_a), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
